dmem_wbuf: RTL and testbench

- Posted store buffer between the single-cycle core's data port (MemWrite/DataAdr/WriteData/ReadData) and a data memory that accepts writes through a valid/ready handshake.
- Stores retire from the core in one cycle into a FIFO and drain to memory in order; loads read memory combinationally.
- Loads are forwarded from, or stalled on, younger buffered stores to the same word.

---
 rtl/dmem_wbuf_pkg.sv | 17 +
 rtl/dmem_wbuf_if.sv | 22 ++
 rtl/dmem_wbuf_fifo.sv | 75 +++++++
 rtl/dmem_wbuf.sv | 93 +++++++++
 tb/tb_dmem_wbuf.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_wbuf_pkg.sv
// Shared types and constants for the dmem_wbuf posted store buffer.
package rvx10_mem_pkg;

    localparam int MEM_AW     = 32;
    localparam int MEM_DW     = 32;
    localparam int WBUF_DEPTH = 4;
    localparam int WBUF_PTR_W = $clog2(WBUF_DEPTH);

    // Low byte-offset bits of every buffered (full-word) store address
    localparam logic [1:0] WORD_ALIGN = 2'b00;

    typedef struct packed {
        logic [MEM_AW-3:0] wadr;
        logic [MEM_DW-1:0] data;
    } wbuf_entry_t;

endpackage

// File: rtl/dmem_wbuf_if.sv
// Memory-side bus of the store buffer: valid/ready drain channel plus combinational read port.
interface dmem_wbuf_if #(
    parameter int AW = rvx10_mem_pkg::MEM_AW,
    parameter int DW = rvx10_mem_pkg::MEM_DW
);
    logic          mem_wvalid;
    logic          mem_wready;
    logic [AW-1:0] mem_wadr;
    logic [DW-1:0] mem_wdata;
    logic [AW-1:0] mem_radr;
    logic [DW-1:0] mem_rdata;

    modport master (
        output mem_wvalid, mem_wadr, mem_wdata, mem_radr,
        input  mem_wready, mem_rdata
    );

    modport slave (
        input  mem_wvalid, mem_wadr, mem_wdata, mem_radr,
        output mem_wready, mem_rdata
    );
endinterface

// File: rtl/dmem_wbuf_fifo.sv
// In-order store FIFO: entry storage, read/write pointers and occupancy count.
module wbuf_fifo
    import rvx10_mem_pkg::*;
#(
    parameter int  DEPTH   = WBUF_DEPTH,
    parameter type entry_t = wbuf_entry_t
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  entry_t                   push_data,
    input  logic                     pop,
    output entry_t                   head,
    output entry_t                   entries [DEPTH],
    output logic [$clog2(DEPTH)-1:0] rd_ptr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic          do_push, do_pop;

    assign full    = (count_q == (PW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        // Push and pop together leave the count alone
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head    = mem_q[rd_ptr_q];
    assign entries = mem_q;
    assign rd_ptr  = rd_ptr_q;
    assign count   = count_q;

endmodule

// File: rtl/dmem_wbuf.sv
// Posted store buffer between the core data port and data memory.
// Optional macro WBUF_FWD_EN forwards load hits from the buffer instead of stalling.
module dmem_wbuf
    import rvx10_mem_pkg::*;
#(
    parameter int DEPTH = WBUF_DEPTH,
    parameter int AW    = MEM_AW,
    parameter int DW    = MEM_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_we,
    input  logic          cpu_re,
    input  logic [AW-1:0] cpu_adr,
    input  logic [DW-1:0] cpu_wd,
    output logic [DW-1:0] cpu_rd,
    output logic          stall,
    output logic          empty,
    dmem_wbuf_if.master   mem
);
    localparam int PW = $clog2(DEPTH);

    wbuf_entry_t   head;
    wbuf_entry_t   push_entry;
    wbuf_entry_t   entries [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          full, fifo_empty;
    logic          push, pop, is_load;
    logic [PW-1:0] idx;
    logic          hit;
`ifdef WBUF_FWD_EN
    logic [DW-1:0] hit_data;
`endif

    // A simultaneous load request is ignored when a store is present
    assign is_load    = cpu_re & ~cpu_we;
    assign push       = cpu_we & ~full;
    assign pop        = mem.mem_wvalid & mem.mem_wready;
    assign push_entry = {cpu_adr[AW-1:2], cpu_wd};

    wbuf_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (wbuf_entry_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .entries   (entries),
        .rd_ptr    (rd_ptr),
        .count     (count),
        .full      (full),
        .empty     (fifo_empty)
    );

    // Walk oldest to youngest so the last match seen is the youngest store
    always_comb begin
        idx = '0;
        hit = 1'b0;
`ifdef WBUF_FWD_EN
        hit_data = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if (({1'b0, PW'(k)} < count) && (entries[idx].wadr == cpu_adr[AW-1:2])) begin
                hit = 1'b1;
`ifdef WBUF_FWD_EN
                hit_data = entries[idx].data;
`endif
            end
        end
    end

    always_comb begin
        stall  = cpu_we & full;
        cpu_rd = mem.mem_rdata;
`ifdef WBUF_FWD_EN
        if (is_load && hit) cpu_rd = hit_data;
`else
        if (is_load && hit) stall = 1'b1;
`endif
    end

    assign empty          = fifo_empty;
    assign mem.mem_wvalid = ~fifo_empty;
    assign mem.mem_wadr   = {head.wadr, WORD_ALIGN};
    assign mem.mem_wdata  = head.data;
    assign mem.mem_radr   = cpu_adr;

endmodule

// File: tb/tb_dmem_wbuf.sv
// Directed self-checking bench for dmem_wbuf with a small word-addressed memory model.
module tb_dmem_wbuf;

`ifdef WBUF_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_we, cpu_re;
    logic [31:0] cpu_adr, cpu_wd, cpu_rd;
    logic        stall, empty;

    int errors = 0;
    int checks = 0;

    logic [31:0] mm [64];
    logic [63:0] drain_q [$];

    dmem_wbuf_if #(.AW(32), .DW(32)) mem_if ();

    dmem_wbuf #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .cpu_we  (cpu_we),
        .cpu_re  (cpu_re),
        .cpu_adr (cpu_adr),
        .cpu_wd  (cpu_wd),
        .cpu_rd  (cpu_rd),
        .stall   (stall),
        .empty   (empty),
        .mem     (mem_if)
    );

    always #5 clk = ~clk;

    // Memory model: accept drained writes and log them in arrival order
    always @(posedge clk) begin
        if (mem_if.mem_wvalid && mem_if.mem_wready) begin
            mm[mem_if.mem_wadr[7:2]] <= mem_if.mem_wdata;
            drain_q.push_back({mem_if.mem_wadr, mem_if.mem_wdata});
        end
    end

    always_comb mem_if.mem_rdata = mm[mem_if.mem_radr[7:2]];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic re, input logic [31:0] adr, input logic [31:0] wd);
        cpu_we  = we;
        cpu_re  = re;
        cpu_adr = adr;
        cpu_wd  = wd;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        mem_if.mem_wready = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        #3;
        checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty: got %b want 1", empty); end
        checks++; if (mem_if.mem_wvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_wvalid: got %b want 0", mem_if.mem_wvalid); end
        checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %b want 0", stall); end
        tick();
        reset = 1'b1;
    endtask

    task automatic test_single_store();
        mem_if.mem_wready = 1'b1;
        drive(1'b1, 1'b0, 32'h60, 32'h1234);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL single_stall: got %b want 0", stall); end
        checks++; if (mem_if.mem_wvalid !== 1'b0) begin errors++; $display("[TB] FAIL single_no_bypass: got %b want 0", mem_if.mem_wvalid); end
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checks++; if (mem_if.mem_wvalid !== 1'b1) begin errors++; $display("[TB] FAIL single_wvalid: got %b want 1", mem_if.mem_wvalid); end
        checks++; if (mem_if.mem_wadr !== 32'h60) begin errors++; $display("[TB] FAIL single_wadr: got %h want 00000060", mem_if.mem_wadr); end
        checks++; if (mem_if.mem_wdata !== 32'h1234) begin errors++; $display("[TB] FAIL single_wdata: got %h want 00001234", mem_if.mem_wdata); end
        checks++; if (empty !== 1'b0) begin errors++; $display("[TB] FAIL single_not_empty: got %b want 0", empty); end
        tick();
        #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL single_empty_after: got %b want 1", empty); end
        checks++; if (mem_if.mem_wvalid !== 1'b0) begin errors++; $display("[TB] FAIL single_wvalid_after: got %b want 0", mem_if.mem_wvalid); end
        checks++; if (mm[6'h18] !== 32'h1234) begin errors++; $display("[TB] FAIL single_mem: got %h want 00001234", mm[6'h18]); end
    endtask

    task automatic test_full_stall();
        int n;
        logic [63:0] exp;
        drain_q.delete();
        mem_if.mem_wready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 32'(4 * i), 32'(32'hA0 + i));
            #1;
            checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL full_accept%0d_stall: got %b want 0", i, stall); end
            tick();
        end
        drive(1'b1, 1'b0, 32'h10, 32'hA4);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL full_fifth_stall: got %b want 1", stall); end
        checks++; if (mem_if.mem_wadr !== 32'h0) begin errors++; $display("[TB] FAIL full_head_adr: got %h want 00000000", mem_if.mem_wadr); end
        tick();
        checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL full_held_stall: got %b want 1", stall); end
        checks++; if (mem_if.mem_wdata !== 32'hA0) begin errors++; $display("[TB] FAIL full_held_wdata: got %h want 000000a0", mem_if.mem_wdata); end
        mem_if.mem_wready = 1'b1;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL full_ready_no_comb: got %b want 1", stall); end
        tick();
        checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL full_room_stall: got %b want 0", stall); end
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        n = 0;
        while (!empty && n < 20) begin tick(); n++; end
        checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL full_drain_timeout: got %b want 1", empty); end
        checks++; if (drain_q.size() != 5) begin errors++; $display("[TB] FAIL full_drain_count: got %0d want 5", drain_q.size()); end
        for (int i = 0; i < 5; i++) begin
            exp = {32'(4 * i), 32'(32'hA0 + i)};
            checks++;
            if (i >= drain_q.size() || drain_q[i] !== exp) begin
                errors++;
                $display("[TB] FAIL full_drain%0d: got %h want %h", i, (i < drain_q.size()) ? drain_q[i] : 64'hx, exp);
            end
        end
    endtask

    task automatic test_back_to_back_wrap();
        int n;
        logic [63:0] exp;
        drain_q.delete();
        mem_if.mem_wready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 32'(32'h20 + 4 * i), 32'(32'hB0 + i));
            tick();
        end
        drive(1'b1, 1'b0, 32'h30, 32'hB4);
        mem_if.mem_wready = 1'b1;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL wrap_full_stall: got %b want 1", stall); end
        tick();
        for (int i = 4; i < 7; i++) begin
            drive(1'b1, 1'b0, 32'(32'h20 + 4 * i), 32'(32'hB0 + i));
            #1;
            checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL wrap_pushpop%0d_stall: got %b want 0", i, stall); end
            tick();
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        n = 0;
        while (!empty && n < 20) begin tick(); n++; end
        checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL wrap_drain_timeout: got %b want 1", empty); end
        checks++; if (drain_q.size() != 7) begin errors++; $display("[TB] FAIL wrap_drain_count: got %0d want 7", drain_q.size()); end
        for (int i = 0; i < 7; i++) begin
            exp = {32'(32'h20 + 4 * i), 32'(32'hB0 + i)};
            checks++;
            if (i >= drain_q.size() || drain_q[i] !== exp) begin
                errors++;
                $display("[TB] FAIL wrap_drain%0d: got %h want %h", i, (i < drain_q.size()) ? drain_q[i] : 64'hx, exp);
            end
        end
    endtask

    task automatic test_load_hit();
        logic [31:0] exp_rd;
        logic        exp_stall;
        mem_if.mem_wready = 1'b0;
        drive(1'b1, 1'b0, 32'h64, 32'd25);
        tick();
        drive(1'b1, 1'b0, 32'h64, 32'd7);
        tick();
        drive(1'b0, 1'b1, 32'h64, 32'h0);
        #1;
        exp_stall = FWD ? 1'b0 : 1'b1;
        exp_rd    = FWD ? 32'd7 : 32'd0;
        checks++; if (stall !== exp_stall) begin errors++; $display("[TB] FAIL hit_two_stall: got %b want %b", stall, exp_stall); end
        checks++; if (cpu_rd !== exp_rd) begin errors++; $display("[TB] FAIL hit_two_rd: got %0d want %0d", cpu_rd, exp_rd); end
        mem_if.mem_wready = 1'b1;
        tick();
        exp_rd = FWD ? 32'd7 : 32'd25;
        checks++; if (stall !== exp_stall) begin errors++; $display("[TB] FAIL hit_one_stall: got %b want %b", stall, exp_stall); end
        checks++; if (cpu_rd !== exp_rd) begin errors++; $display("[TB] FAIL hit_one_rd: got %0d want %0d", cpu_rd, exp_rd); end
        tick();
        checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL hit_drained_stall: got %b want 0", stall); end
        checks++; if (cpu_rd !== 32'd7) begin errors++; $display("[TB] FAIL hit_drained_rd: got %0d want 7", cpu_rd); end
        checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL hit_drained_empty: got %b want 1", empty); end
        drive(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_load_miss();
        mem_if.mem_wready = 1'b0;
        drive(1'b1, 1'b0, 32'h84, 32'h99);
        tick();
        drive(1'b0, 1'b1, 32'h80, 32'h0);
        #1;
        checks++; if (cpu_rd !== 32'h5A5A) begin errors++; $display("[TB] FAIL miss_rd: got %h want 00005a5a", cpu_rd); end
        checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL miss_stall: got %b want 0", stall); end
        checks++; if (mem_if.mem_radr !== 32'h80) begin errors++; $display("[TB] FAIL miss_radr: got %h want 00000080", mem_if.mem_radr); end
        tick();
    endtask

    task automatic test_reset_pending();
        drive(1'b1, 1'b0, 32'h88, 32'h77);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checks++; if (mem_if.mem_wvalid !== 1'b1) begin errors++; $display("[TB] FAIL rstp_pending_wvalid: got %b want 1", mem_if.mem_wvalid); end
        #1 reset = 1'b0;
        #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL rstp_empty: got %b want 1", empty); end
        checks++; if (mem_if.mem_wvalid !== 1'b0) begin errors++; $display("[TB] FAIL rstp_wvalid: got %b want 0", mem_if.mem_wvalid); end
        tick();
        reset = 1'b1;
        mem_if.mem_wready = 1'b1;
        drain_q.delete();
        repeat (4) tick();
        checks++; if (drain_q.size() != 0) begin errors++; $display("[TB] FAIL rstp_no_drain: got %0d want 0", drain_q.size()); end
        checks++; if (mm[6'h21] !== 32'h0) begin errors++; $display("[TB] FAIL rstp_mem_untouched: got %h want 00000000", mm[6'h21]); end
        checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL rstp_empty_after: got %b want 1", empty); end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 64; i++) mm[i] = 32'h0;
        mm[6'h20] = 32'h5A5A;
        $display("[TB] starting dmem_wbuf bench (forwarding=%0d)", FWD);
        test_reset();
        test_single_store();
        test_full_stall();
        test_back_to_back_wrap();
        test_load_hit();
        test_load_miss();
        test_reset_pending();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
